// File: rtl/seg_display_driver.sv
// seg_display_driver
// Converts a 14-bit binary value (saturated to 9999) to four BCD digits with
// a sequential double-dabble converter, then time-multiplexes the digits onto
// a 4-digit active-low common-anode seven-segment display with leading-zero
// blanking.
module seg_display_driver #(
   parameter int unsigned REFRESH_TICKS = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] number,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        dp,
   output logic        busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [13:0] SAT_MAX  = 14'd9999;
   localparam logic [3:0]  LAST_SH  = 4'd13;
   localparam logic [19:0] LAST_REF = 20'(REFRESH_TICKS - 1);

   state_t      state, state_nx;
   logic [13:0] cap, cap_nx;
   logic [29:0] sh, sh_nx;
   logic [3:0]  cnt, cnt_nx;
   logic [15:0] bcd_reg, bcd_nx;
   logic [19:0] ref_cnt;
   logic [1:0]  idx;

   logic [13:0] sat;
   logic [29:0] adj;
   logic [29:0] shifted;
   logic [3:0]  digit;
   logic        blank;

   // Clamp the incoming value to the largest displayable number.
   always_comb begin
      sat = (number > SAT_MAX) ? SAT_MAX : number;
   end

   // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
   always_comb begin
      adj = sh;
      for (int unsigned i = 0; i < 4; i++) begin
         if (sh[14 + 4*i +: 4] >= 4'd5) begin
            adj[14 + 4*i +: 4] = sh[14 + 4*i +: 4] + 4'd3;
         end
      end
      shifted = {adj[28:0], 1'b0};
   end

   // Conversion state and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cap     <= '0;
         sh      <= '0;
         cnt     <= '0;
         bcd_reg <= '0;
      end else begin
         state   <= state_nx;
         cap     <= cap_nx;
         sh      <= sh_nx;
         cnt     <= cnt_nx;
         bcd_reg <= bcd_nx;
      end
   end

   // Next-state and datapath update; bcd_reg only loads on the final shift
   // so the display never shows a partially converted value.
   always_comb begin
      state_nx = state;
      cap_nx   = cap;
      sh_nx    = sh;
      cnt_nx   = cnt;
      bcd_nx   = bcd_reg;
      case (state)
         IDLE: begin
            if (sat != cap) begin
               cap_nx   = sat;
               sh_nx    = {16'b0, sat};
               cnt_nx   = '0;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            sh_nx  = shifted;
            cnt_nx = cnt + 4'd1;
            if (cnt == LAST_SH) begin
               bcd_nx   = shifted[29:14];
               state_nx = IDLE;
            end
         end
      endcase
   end

   // Refresh timer: each digit stays lit for REFRESH_TICKS clocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_cnt <= '0;
         idx     <= '0;
      end else if (ref_cnt == LAST_REF) begin
         ref_cnt <= '0;
         idx     <= idx + 2'd1;
      end else begin
         ref_cnt <= ref_cnt + 20'd1;
      end
   end

   // Select the active digit and decide whether it is a leading zero.
   always_comb begin
      digit = '0;
      blank = 1'b0;
      case (idx)
         2'd0: begin
            digit = bcd_reg[3:0];
            blank = 1'b0;
         end
         2'd1: begin
            digit = bcd_reg[7:4];
            blank = (bcd_reg[15:4] == 12'd0);
         end
         2'd2: begin
            digit = bcd_reg[11:8];
            blank = (bcd_reg[15:8] == 8'd0);
         end
         2'd3: begin
            digit = bcd_reg[15:12];
            blank = (bcd_reg[15:12] == 4'd0);
         end
      endcase
   end

   // Anode select (active-low), forced off for blanked digits.
   always_comb begin
      if (blank) begin
         an = '1;
      end else begin
         an = ~(4'b0001 << idx);
      end
   end

   // Seven-segment decode {g,f,e,d,c,b,a}, active-low.
   always_comb begin
      seg = '1;
      case (digit)
         4'd0: seg = 7'b1000000;
         4'd1: seg = 7'b1111001;
         4'd2: seg = 7'b0100100;
         4'd3: seg = 7'b0110000;
         4'd4: seg = 7'b0011001;
         4'd5: seg = 7'b0010010;
         4'd6: seg = 7'b0000010;
         4'd7: seg = 7'b1111000;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0010000;
         default: seg = '1;
      endcase
   end

   assign dp   = 1'b1;
   assign busy = (state == SHIFT);

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with a short refresh period so the
// digit scan can be observed within a few clocks.
module tb_seg_display_driver;

   logic        clk;
   logic        rst;
   logic [13:0] number;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;
   logic        busy;

   int total;
   int bad;
   int cyc;   // rising edges since reset release

   seg_display_driver #(.REFRESH_TICKS(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .number (number),
      .seg    (seg),
      .an     (an),
      .dp     (dp),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used to predict which digit is being scanned.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [3:0] exp_an [4];
      int k;
      exp_an[0] = 4'b1110; exp_an[1] = 4'b1111;
      exp_an[2] = 4'b1111; exp_an[3] = 4'b1111;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (an !== 4'b1110) begin bad++; $display("FAIL reset_an got=%b exp=1110", an); end
      total++; if (seg !== 7'b1000000) begin bad++; $display("FAIL reset_seg got=%b exp=1000000", seg); end
      total++; if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b exp=1", dp); end
      total++; if (dut.bcd_reg !== 16'h0000) begin bad++; $display("FAIL reset_bcd got=%h exp=0000", dut.bcd_reg); end
      for (int i = 0; i < 16; i++) begin
         tick();
         k = (cyc / 4) % 4;
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy cyc=%0d got=%b exp=0", cyc, busy); end
         total++; if (an !== exp_an[k]) begin bad++; $display("FAIL reset_scan_an cyc=%0d got=%b exp=%b", cyc, an, exp_an[k]); end
         if (k == 0) begin
            total++; if (seg !== 7'b1000000) begin bad++; $display("FAIL reset_scan_seg cyc=%0d got=%b exp=1000000", cyc, seg); end
         end
      end
   endtask

   task automatic test_convert_1234();
      logic [3:0] exp_an [4];
      logic [6:0] exp_seg [4];
      int k;
      exp_an[0] = 4'b1110; exp_seg[0] = 7'b0011001;
      exp_an[1] = 4'b1101; exp_seg[1] = 7'b0110000;
      exp_an[2] = 4'b1011; exp_seg[2] = 7'b0100100;
      exp_an[3] = 4'b0111; exp_seg[3] = 7'b1111001;
      number = 14'd1234;
      for (int n = 0; n < 14; n++) begin
         tick();
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL c1234_busy after E%0d got=%b exp=1", n, busy); end
         total++; if (dut.bcd_reg !== 16'h0000) begin bad++; $display("FAIL c1234_hold after E%0d got=%h exp=0000", n, dut.bcd_reg); end
      end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL c1234_busy_fall got=%b exp=0", busy); end
      total++; if (dut.bcd_reg !== 16'h1234) begin bad++; $display("FAIL c1234_bcd got=%h exp=1234", dut.bcd_reg); end
      for (int i = 0; i < 16; i++) begin
         tick();
         k = (cyc / 4) % 4;
         total++; if (an !== exp_an[k]) begin bad++; $display("FAIL c1234_an idx=%0d got=%b exp=%b", k, an, exp_an[k]); end
         total++; if (seg !== exp_seg[k]) begin bad++; $display("FAIL c1234_seg idx=%0d got=%b exp=%b", k, seg, exp_seg[k]); end
      end
   endtask

   task automatic test_blanking_507();
      logic [3:0] exp_an [4];
      logic [6:0] exp_seg [4];
      int k;
      exp_an[0] = 4'b1110; exp_seg[0] = 7'b1111000;
      exp_an[1] = 4'b1101; exp_seg[1] = 7'b1000000;
      exp_an[2] = 4'b1011; exp_seg[2] = 7'b0010010;
      exp_an[3] = 4'b1111; exp_seg[3] = 7'b1000000;
      number = 14'd507;
      for (int n = 0; n < 14; n++) begin
         tick();
         total++; if (dut.bcd_reg !== 16'h1234) begin bad++; $display("FAIL c507_hold after E%0d got=%h exp=1234", n, dut.bcd_reg); end
      end
      tick();
      total++; if (dut.bcd_reg !== 16'h0507) begin bad++; $display("FAIL c507_bcd got=%h exp=0507", dut.bcd_reg); end
      for (int i = 0; i < 16; i++) begin
         tick();
         k = (cyc / 4) % 4;
         total++; if (an !== exp_an[k]) begin bad++; $display("FAIL c507_an idx=%0d got=%b exp=%b", k, an, exp_an[k]); end
         if (k != 3) begin
            total++; if (seg !== exp_seg[k]) begin bad++; $display("FAIL c507_seg idx=%0d got=%b exp=%b", k, seg, exp_seg[k]); end
         end
      end
   endtask

   task automatic test_saturate();
      logic [3:0] exp_an [4];
      int k;
      exp_an[0] = 4'b1110; exp_an[1] = 4'b1101;
      exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
      number = 14'd12000;
      repeat (15) tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL sat_busy got=%b exp=0", busy); end
      total++; if (dut.bcd_reg !== 16'h9999) begin bad++; $display("FAIL sat_bcd got=%h exp=9999", dut.bcd_reg); end
      number = 14'd16383;
      for (int i = 0; i < 20; i++) begin
         tick();
         k = (cyc / 4) % 4;
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL sat_nostart_busy i=%0d got=%b exp=0", i, busy); end
         total++; if (an !== exp_an[k]) begin bad++; $display("FAIL sat_an idx=%0d got=%b exp=%b", k, an, exp_an[k]); end
         total++; if (seg !== 7'b0010000) begin bad++; $display("FAIL sat_seg idx=%0d got=%b exp=0010000", k, seg); end
      end
      total++; if (dut.bcd_reg !== 16'h9999) begin bad++; $display("FAIL sat_keep got=%h exp=9999", dut.bcd_reg); end
   endtask

   task automatic test_back_to_back();
      number = 14'd100;
      for (int n = 0; n < 14; n++) begin
         tick();
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy1 after E%0d got=%b exp=1", n, busy); end
         if (n == 2) number = 14'd42;
      end
      tick();
      total++; if (dut.bcd_reg !== 16'h0100) begin bad++; $display("FAIL b2b_first got=%h exp=0100", dut.bcd_reg); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b exp=0", busy); end
      for (int n = 15; n < 29; n++) begin
         tick();
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy2 after E%0d got=%b exp=1", n, busy); end
         total++; if (dut.bcd_reg !== 16'h0100) begin bad++; $display("FAIL b2b_hold after E%0d got=%h exp=0100", n, dut.bcd_reg); end
      end
      tick();
      total++; if (dut.bcd_reg !== 16'h0042) begin bad++; $display("FAIL b2b_second got=%h exp=0042", dut.bcd_reg); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_end_busy got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid();
      number = 14'd8888;
      repeat (8) tick();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_pre got=%b exp=1", busy); end
      rst = 1'b1;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy_rst got=%b exp=0", busy); end
      total++; if (dut.bcd_reg !== 16'h0000) begin bad++; $display("FAIL rmid_bcd_rst got=%h exp=0000", dut.bcd_reg); end
      tick();
      rst = 1'b0;
      for (int n = 0; n < 14; n++) begin
         tick();
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy after E%0d got=%b exp=1", n, busy); end
         total++; if (dut.bcd_reg !== 16'h0000) begin bad++; $display("FAIL rmid_hold after E%0d got=%h exp=0000", n, dut.bcd_reg); end
      end
      tick();
      total++; if (dut.bcd_reg !== 16'h8888) begin bad++; $display("FAIL rmid_bcd got=%h exp=8888", dut.bcd_reg); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy_end got=%b exp=0", busy); end
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      rst    = 1'b1;
      number = 14'd0;
      repeat (2) tick();
      rst = 1'b0;
      test_reset();
      test_convert_1234();
      test_blanking_507();
      test_saturate();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "simulation time limit");
   end

endmodule
